// File: rtl/bcd_counter_chain_pkg.sv
// Shared constants and helpers for the BCD counter chain.
package bcd_counter_chain_pkg;

    localparam int MOD_MAX = 10;
    localparam int DIGIT_W = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Extract the modulus of digit idx from the packed 4-bit-per-digit table.
    function automatic int get_mod(input logic [31:0] mods, input int idx);
        return int'(mods[idx*DIGIT_W +: DIGIT_W]);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with its own modulus: parallel load with clamp, step up/down with wrap.
module bcd_digit
    import bcd_counter_chain_pkg::*;
#(
    parameter int MOD = MOD_MAX
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               loadn,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               step,
    input  logic               up,
    output logic [DIGIT_W-1:0] q,
    output logic               at_max,
    output logic               at_min
);

    // A modulus above a decimal digit cannot be represented; cap it.
    localparam int MOD_C = (MOD > MOD_MAX) ? MOD_MAX : MOD;
    localparam logic [DIGIT_W-1:0] LIMIT = DIGIT_W'(MOD_C);
    localparam logic [DIGIT_W-1:0] TOP   = DIGIT_W'(MOD_C - 1);

    logic [DIGIT_W-1:0] cnt_q;
    logic [DIGIT_W-1:0] cnt_d;
    logic [DIGIT_W-1:0] clamped;

    // Out-of-range load values (including non-BCD codes) become the digit maximum.
    assign clamped = (load_val >= LIMIT) ? TOP : load_val;
    assign at_max  = (cnt_q == TOP);
    assign at_min  = (cnt_q == '0);
    assign q       = cnt_q;

    // Next value: load beats step; stepping wraps at either end of the digit range.
    always_comb begin
        cnt_d = cnt_q;
        if (!loadn) begin
            cnt_d = clamped;
        end else if (step) begin
            if (up == DIR_UP) begin
                cnt_d = at_max ? '0 : cnt_q + 1'b1;
            end else begin
                cnt_d = at_min ? TOP : cnt_q - 1'b1;
            end
        end
    end

    // Digit register, cleared asynchronously.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_counter_chain.sv
// Cascade of BCD digits counting up/down as one number, with load, saturation and flags.
module bcd_counter_chain
    import bcd_counter_chain_pkg::*;
#(
    parameter int                    DIGITS   = 4,
    parameter logic [4*DIGITS-1:0]   MODS     = (4*DIGITS)'(16'h6A6A),
    parameter bit                    SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  loadn,
    input  logic                  en,
    input  logic                  up,
    input  logic [4*DIGITS-1:0]   data,
    output logic [4*DIGITS-1:0]   out,
    output logic                  tc,
    output logic                  zero
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step;
    logic [DIGITS:0]   low_max;
    logic [DIGITS:0]   low_min;
    logic              all_max;
    logic              all_min;
    logic              hold_zero;

    // Carry/borrow lookahead: bit i says every digit below i is at its max (or at zero).
    always_comb begin
        low_max    = '0;
        low_min    = '0;
        low_max[0] = 1'b1;
        low_min[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            low_max[i+1] = low_max[i] & at_max[i];
            low_min[i+1] = low_min[i] & at_min[i];
        end
    end

    assign all_max   = low_max[DIGITS];
    assign all_min   = low_min[DIGITS];
    // Counting down from all-zero either sticks at zero or wraps to all-max.
    assign hold_zero = SATURATE && (up == DIR_DOWN) && all_min;

    // Per-digit step enable; all digits update on the same edge.
    always_comb begin
        step = '0;
        for (int i = 0; i < DIGITS; i++) begin
            step[i] = en & ~hold_zero & ((up == DIR_UP) ? low_max[i] : low_min[i]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit #(
            .MOD (get_mod(32'(MODS), g))
        ) u_digit (
            .clk      (clk),
            .clrn     (clrn),
            .loadn    (loadn),
            .load_val (data[g*DIGIT_W +: DIGIT_W]),
            .step     (step[g]),
            .up       (up),
            .q        (out[g*DIGIT_W +: DIGIT_W]),
            .at_max   (at_max[g]),
            .at_min   (at_min[g])
        );
    end

    assign tc   = en & ((up == DIR_UP) ? all_max : all_min);
    assign zero = (out == '0);

endmodule
